multicycle_control_unit: RTL
============================

Name: multicycle_control_unit

Overview:
- Successor to the single-cycle decoder: a parametrised multi-cycle control FSM for the LEGv8-style core with a shared instruction/data memory.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and waits on a memory ready handshake with a timeout.
- Adds a HALT opcode, illegal-opcode trapping and a retired-instruction counter.
- Sits between the IR/opcode field and the datapath muxes, register file and memory port.

Parameters:
- OPCODE_W, 4, opcode width; opcode values below are zero-extended to this width.
- ALU_OP_W, 3, alu_op width; ADD=0, SUB=1.
- MEM_TIMEOUT, 16, maximum wait cycles for mem_ready; 0 disables the timeout.
- CNT_W, 32, width of instr_count.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  OPCODE_W  opcode field from IR; valid from DECODE onward.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request valid.
- mem_read_en  out  1  read request.
- mem_write_en  out  1  write request.
- addr_sel  out  1  memory address source: 0=PC, 1=ALU result.
- ir_write_en  out  1  load IR.
- pc_write_en  out  1  load PC with PC+4.
- alu_src_a_sel  out  1  ALU A source: 0=reg A, 1=PC.
- alu_src_b_sel  out  2  ALU B source: 00=reg B, 01=const 4, 10=imm.
- alu_op  out  ALU_OP_W  ALU operation.
- reg_write_en  out  1  register file write.
- mem_to_reg_sel  out  2  writeback source: 00=ALU, 01=MDR.
- rd_sel_i_type  out  1  selects the I-type rd field.
- branch_en  out  1  conditional branch (datapath qualifies with zero).
- jump_en  out  1  jump.
- retire  out  1  one-cycle pulse when an instruction completes.
- instr_count  out  CNT_W  count of retired instructions.
- state  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- halted  out  1  FSM is in HALT.
- illegal_op  out  1  sticky: illegal opcode seen.
- bus_error  out  1  sticky: memory timeout.

Behaviour:
- Opcodes: R=0, LW=1, SW=2, BEQ=3, JUMP=4, ADDI=5, HALT=15. All other values are illegal.
- Reset (synchronous, active-high):
  - Next state FETCH; instr_count, illegal_op, bus_error, op_q and wait_cnt all cleared.
  - While reset is high, every enable/strobe output and retire are forced 0.
  - Reset in any state, including HALT or mid-wait, aborts the instruction. The first cycle after deassertion is FETCH.
- Outputs are combinational from state and op_q; anything not listed below is 0.
- FETCH:
  - Outputs: mem_req=1, mem_read_en=1, addr_sel=0, alu_src_a_sel=1, alu_src_b_sel=01, alu_op=ADD.
  - If mem_ready: ir_write_en=1, pc_write_en=1, next state DECODE. Otherwise stay.
- DECODE:
  - op_q <= opcode.
  - Next state: HALT for the HALT opcode; HALT with illegal_op<=1 for an illegal opcode; otherwise EXEC.
- EXEC, by op_q:
  - R: alu_src_b_sel=00, alu_op=ADD; next WB.
  - ADDI: alu_src_b_sel=10, alu_op=ADD; next WB.
  - LW/SW: alu_src_b_sel=10, alu_op=ADD; next MEM.
  - BEQ: alu_op=SUB, branch_en=1, retire=1; next FETCH.
  - JUMP: jump_en=1, retire=1; next FETCH.
- MEM:
  - Outputs: mem_req=1, addr_sel=1; mem_read_en=1 for LW, mem_write_en=1 for SW.
  - On mem_ready: LW goes to WB; SW asserts retire=1 and goes to FETCH. Otherwise stay.
- WB:
  - reg_write_en=1, retire=1; next FETCH.
  - LW: mem_to_reg_sel=01, rd_sel_i_type=1. ADDI: rd_sel_i_type=1. R: mem_to_reg_sel=00, rd_sel_i_type=0.
- HALT: all enables 0, halted=1; the FSM stays in HALT until reset.
- Wait timeout (FETCH and MEM):
  - wait_cnt clears on state entry and increments each cycle mem_ready is low.
  - If MEM_TIMEOUT>0 and mem_ready is low in the MEM_TIMEOUT-th cycle of the wait, the next state is HALT and bus_error<=1.
  - If mem_ready is high in that same cycle, the ready wins and no error is raised.
- instr_count increments on retire and wraps modulo 2^CNT_W.
- Minimum cycles per instruction with zero wait states: BEQ/JUMP 3, R/ADDI/SW 4, LW 5.

Test Plan:
- Reset 2 cycles, then ADDI (5) with mem_ready always 1 -> states 0,1,2,4,0; rd_sel_i_type=1 in WB; retire pulses once; instr_count=1.
- LW (1) with mem_ready held low 3 cycles in MEM -> MEM lasts 4 cycles; WB has mem_to_reg_sel=01; total 8 cycles; instr_count increments by 1.
- BEQ (3) -> EXEC shows alu_op=1, branch_en=1, retire=1; next state FETCH after 3 cycles total.
- Opcode 7 -> DECODE goes to HALT; illegal_op=1, halted=1, no retire; mem_req stays 0 for 10 cycles; reset returns to FETCH with illegal_op=0.
- MEM_TIMEOUT=4, mem_ready low in FETCH -> after 4 FETCH cycles, HALT with bus_error=1. A variant with mem_ready high in the 4th cycle -> DECODE, no error.
- CNT_W=2, 4 JUMPs (4) -> instr_count sequence 1,2,3,0. Reset asserted mid-MEM of an SW -> no mem_write_en while in reset; FETCH on the first cycle after deassertion.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM for the LEGv8-style core: FETCH/DECODE/EXEC/MEM/WB with HALT.
// Strobes are combinational from state/op_q; memory waits are bounded by MEM_TIMEOUT.
module multicycle_control_unit #(
  parameter int OPCODE_W    = 4,
  parameter int ALU_OP_W    = 3,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_read_en,
  output logic                mem_write_en,
  output logic                addr_sel,
  output logic                ir_write_en,
  output logic                pc_write_en,
  output logic                alu_src_a_sel,
  output logic [1:0]          alu_src_b_sel,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                reg_write_en,
  output logic [1:0]          mem_to_reg_sel,
  output logic                rd_sel_i_type,
  output logic                branch_en,
  output logic                jump_en,
  output logic                retire,
  output logic [CNT_W-1:0]    instr_count,
  output logic [2:0]          state,
  output logic                halted,
  output logic                illegal_op,
  output logic                bus_error
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_JUMP = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_HALT = OPCODE_W'(15);

  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(1);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]    instr_count_q, instr_count_d;
  logic                illegal_op_q, illegal_op_d;
  logic                bus_error_q, bus_error_d;
  logic                timeout_hit;
  logic                op_legal;

  assign state       = state_q;
  assign halted      = (state_q == S_HALT);
  assign instr_count = instr_count_q;
  assign illegal_op  = illegal_op_q;
  assign bus_error   = bus_error_q;

  // Datapath controls; selects follow the state, strobes are killed during reset.
  always_comb begin
    mem_req        = 1'b0;
    mem_read_en    = 1'b0;
    mem_write_en   = 1'b0;
    addr_sel       = 1'b0;
    ir_write_en    = 1'b0;
    pc_write_en    = 1'b0;
    alu_src_a_sel  = 1'b0;
    alu_src_b_sel  = 2'b00;
    alu_op         = ALU_ADD;
    reg_write_en   = 1'b0;
    mem_to_reg_sel = 2'b00;
    rd_sel_i_type  = 1'b0;
    branch_en      = 1'b0;
    jump_en        = 1'b0;
    retire         = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req       = 1'b1;
        mem_read_en   = 1'b1;
        alu_src_a_sel = 1'b1;
        alu_src_b_sel = 2'b01;
        ir_write_en   = mem_ready;
        pc_write_en   = mem_ready;
      end
      S_EXEC: begin
        case (op_q)
          OP_ADDI, OP_LW, OP_SW: alu_src_b_sel = 2'b10;
          OP_BEQ: begin
            alu_op    = ALU_SUB;
            branch_en = 1'b1;
            retire    = 1'b1;
          end
          OP_JUMP: begin
            jump_en = 1'b1;
            retire  = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        mem_req      = 1'b1;
        addr_sel     = 1'b1;
        mem_read_en  = (op_q == OP_LW);
        mem_write_en = (op_q == OP_SW);
        retire       = (op_q == OP_SW) && mem_ready;
      end
      S_WB: begin
        reg_write_en   = 1'b1;
        retire         = 1'b1;
        mem_to_reg_sel = (op_q == OP_LW) ? 2'b01 : 2'b00;
        rd_sel_i_type  = (op_q == OP_LW) || (op_q == OP_ADDI);
      end
      default: ;
    endcase
    if (reset) begin
      mem_req      = 1'b0;
      mem_read_en  = 1'b0;
      mem_write_en = 1'b0;
      ir_write_en  = 1'b0;
      pc_write_en  = 1'b0;
      reg_write_en = 1'b0;
      branch_en    = 1'b0;
      jump_en      = 1'b0;
      retire       = 1'b0;
    end
  end

  always_comb begin
    op_legal = (opcode == OP_R)   || (opcode == OP_LW)   || (opcode == OP_SW) ||
               (opcode == OP_BEQ) || (opcode == OP_JUMP) || (opcode == OP_ADDI);
    // The wait counter sits at WAIT_LAST during the MEM_TIMEOUT-th wait cycle.
    timeout_hit   = (MEM_TIMEOUT > 0) && !mem_ready && (wait_cnt_q == WAIT_LAST);
    state_d       = state_q;
    op_d          = op_q;
    illegal_op_d  = illegal_op_q;
    bus_error_d   = bus_error_q;
    instr_count_d = retire ? instr_count_q + CNT_W'(1) : instr_count_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d     = S_HALT;
          bus_error_d = 1'b1;
        end
      end
      S_DECODE: begin
        op_d = opcode;
        if (opcode == OP_HALT) begin
          state_d = S_HALT;
        end else if (op_legal) begin
          state_d = S_EXEC;
        end else begin
          state_d      = S_HALT;
          illegal_op_d = 1'b1;
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_R, OP_ADDI: state_d = S_WB;
          OP_LW, OP_SW:  state_d = S_MEM;
          default:       state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
        end else if (timeout_hit) begin
          state_d     = S_HALT;
          bus_error_d = 1'b1;
        end
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = S_HALT;
    endcase
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (!mem_ready && ((state_q == S_FETCH) || (state_q == S_MEM))) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_FETCH;
      op_q          <= '0;
      wait_cnt_q    <= '0;
      instr_count_q <= '0;
      illegal_op_q  <= 1'b0;
      bus_error_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      wait_cnt_q    <= wait_cnt_d;
      instr_count_q <= instr_count_d;
      illegal_op_q  <= illegal_op_d;
      bus_error_q   <= bus_error_d;
    end
  end

endmodule
